// File: rtl/booth_pp_accumulator.sv
// Sequential radix-2 Booth multiplier back end: one recoded digit of y per cycle, accumulated into an exact signed 2*WIDE-bit product.
// Optional build macro BOOTH_ACC_EARLY_EXIT_EN: finish as soon as the remaining multiplier digits are all zero.
module booth_pp_accumulator #(
  parameter int WIDE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDE-1:0]     x,
  input  logic [WIDE-1:0]     y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*WIDE-1:0]   product
);

  localparam int PW = 2 * WIDE;
  localparam int CW = $clog2(WIDE);
  localparam logic [CW-1:0] LAST = CW'(WIDE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] mcand;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_next;
  logic [WIDE:0] shifter;
  logic [CW-1:0] cnt;
  logic          last_digit;

  // Handshakes: a transfer happens on any rising edge where valid and ready are both high;
  // ready/valid come straight from the state register, and data is held until the transfer.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // mcand is pre-shifted each RUN cycle, so it always equals the sign-extended x << cnt.
  always_comb begin
    acc_next = acc;
    case (shifter[1:0])
      2'b01:   acc_next = acc + mcand;
      2'b10:   acc_next = acc - mcand;
      default: acc_next = acc;
    endcase
  end

`ifdef BOOTH_ACC_EARLY_EXIT_EN
  // shifter[WIDE:1] holds y[WIDE-1:i] (sign-extended); uniform bits mean every later digit is 00 or 11.
  logic rest_uniform;
  assign rest_uniform = (shifter[WIDE:1] == '0) || (&shifter[WIDE:1]);
  assign last_digit   = (cnt == LAST) || rest_uniform;
`else
  assign last_digit   = (cnt == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      shifter <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand   <= {{WIDE{x[WIDE-1]}}, x};
            shifter <= {y, 1'b0};
            acc     <= '0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          acc     <= acc_next;
          mcand   <= mcand << 1;
          shifter <= {shifter[WIDE], shifter[WIDE:1]};
          cnt     <= cnt + CW'(1);
          if (last_digit) begin
            product <= acc_next;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Self-checking bench for booth_pp_accumulator (WIDE=8): vector table, random pairs, backpressure,
// mid-operation reset and back-to-back streaming, with an expected-product queue.
module tb_booth_pp_accumulator;

  localparam int WIDE = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  booth_pp_accumulator #(.WIDE(WIDE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [15:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] m;
    m = $signed(a) * $signed(b);
    return m;
  endfunction

  function automatic int exp_lat(input logic [7:0] vy);
    int lat;
    lat = WIDE;
`ifdef BOOTH_ACC_EARLY_EXIT_EN
    for (int i = WIDE - 1; i >= 0; i--) begin
      logic [7:0] s;
      s = $signed(vy) >>> i;
      if (s == 8'h00 || s == 8'hFF) lat = i + 1;
    end
`endif
    return lat;
  endfunction

  // driver: one full operation; hold = cycles out_ready stays low after out_valid appears
  task automatic do_op(input string name, input logic [7:0] ax, input logic [7:0] ay,
                       input logic [15:0] exp, input int hold);
    int cyc;
    int lat;
    logic [15:0] held;
    out_ready = (hold == 0);
    x = ax;
    y = ay;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 8'($urandom);
    y = 8'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    lat = cyc;
    check({name, "_latency"}, lat, exp_lat(ay));
    if (out_valid && exp_q.size() > 0) begin
      check({name, "_product"}, product, exp_q.pop_front());
    end else begin
      exp_q.delete();
    end
    held = product;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      x = 8'($urandom);
      y = 8'($urandom);
      @(posedge clk); #1;
      cyc++;
      check({name, "_hold_valid"}, {out_valid, in_ready}, 2'b10);
      check({name, "_hold_product"}, product, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (!in_ready && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_ready_low_cycles"}, cyc, lat + 1 + hold);
    check({name, "_out_valid_cleared"}, out_valid, 1'b0);
  endtask

  task automatic back_to_back();
    int cyc;
    int acc_cnt;
    int got;
    int last_acc;
    logic took;
    out_ready = 1'b1;
    x = 8'($urandom);
    y = 8'($urandom);
    in_valid = 1'b1;
    acc_cnt = 0;
    got = 0;
    cyc = 0;
    last_acc = 0;
    while (got < 10 && cyc < 400) begin
      took = in_valid && in_ready;
      if (took) begin
        exp_q.push_back(model(x, y));
`ifndef BOOTH_ACC_EARLY_EXIT_EN
        if (acc_cnt > 0) check("b2b_spacing", cyc - last_acc, WIDE + 2);
`endif
        last_acc = cyc;
        acc_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        if (acc_cnt == 10) in_valid = 1'b0;
        else begin
          x = 8'($urandom);
          y = 8'($urandom);
        end
      end
      if (out_valid) begin
        got++;
        if (exp_q.size() > 0) check("b2b_product", product, exp_q.pop_front());
        else check("b2b_unexpected_output", 1'b1, 1'b0);
      end
    end
    check("b2b_count", got, 10);
    in_valid = 1'b0;
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic [15:0] vp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int no_valid;
    vecs[0]  = '{8'h03, 8'h05, 16'h000F};
    vecs[1]  = '{8'h80, 8'h80, 16'h4000};
    vecs[2]  = '{8'hFF, 8'h7F, 16'hFF81};
    vecs[3]  = '{8'h7F, 8'h80, 16'hC080};
    vecs[4]  = '{8'h00, 8'h00, 16'h0000};
    vecs[5]  = '{8'h07, 8'h01, 16'h0007};
    vecs[6]  = '{8'h07, 8'hFF, 16'hFFF9};
    vecs[7]  = '{8'h05, 8'h40, 16'h0140};
    vecs[8]  = '{8'h80, 8'h7F, 16'hC080};
    vecs[9]  = '{8'h01, 8'h80, 16'hFF80};
    vecs[10] = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[11] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[12] = '{8'h80, 8'h01, 16'hFF80};
    vecs[13] = '{8'hAA, 8'h55, 16'hE372};

    // reset
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = 8'h00;
    y = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_product", product, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // vector table, out_ready held high
    for (int i = 0; i < 14; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].vx, vecs[i].vy, vecs[i].vp, 0);
    end

    // backpressure, then an accept one cycle after the output handshake
    do_op("backpressure", 8'h03, 8'h05, 16'h000F, 5);
    do_op("after_bp", 8'hF3, 8'h11, model(8'hF3, 8'h11), 0);

    // reset in the middle of RUN
    x = 8'h03;
    y = 8'h75;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", in_ready, 1'b1);
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_product", product, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    no_valid = 0;
    for (int c = 0; c < WIDE + 2; c++) begin
      @(posedge clk); #1;
      if (out_valid) no_valid++;
    end
    check("midreset_stale_valid", no_valid, 0);
    do_op("post_reset", 8'h03, 8'h05, 16'h000F, 0);

    // random pairs with random backpressure
    for (int i = 0; i < 120; i++) begin
      logic [7:0] rx;
      logic [7:0] ry;
      rx = 8'($urandom);
      ry = 8'($urandom);
      do_op("rand", rx, ry, model(rx, ry), $urandom_range(0, 2));
    end

    back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
